// File: rtl/drop_pkg.sv
// drop_pkg: shared definitions for the baggage-drop sequencer.
//   - state encodings ST_IDLE..ST_COOL (3-bit)
//   - temperature width
//   - is_cold(): unsigned strict less-than; equality counts as hot
package drop_pkg;

   localparam int ST_W   = 3;
   localparam int TEMP_W = 16;

   typedef enum logic [ST_W-1:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_DROP   = 3'd2,
      ST_COOL   = 3'd3
   } state_e;

   function automatic logic is_cold(input logic [TEMP_W-1:0] t_act,
                                    input logic [TEMP_W-1:0] t_lim);
      return (t_act < t_lim);
   endfunction

endpackage

// File: rtl/cycle_timer.sv
// cycle_timer: loadable down-counter with enable and zero flag.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   load         load load_val (wins over en)
//   load_val     value to load
//   en           decrement by one when non-zero
//   zero         counter currently equals 0
module cycle_timer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (en && (cnt_q != '0))
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/drop_sequencer.sv
// drop_sequencer: sequences a baggage drop. On a request it waits for
// SETTLE_CYC consecutive cold samples (t_act < t_lim), bounded by
// TIMEOUT_CYC, then holds drop_en for DROP_CYC cycles, then cools down
// for COOL_CYC cycles. A hot sample during the drop aborts it.
// Optional feature macro: DROP_AUTO_RETRY_EN -- after an abort, the
// cooldown returns to SETTLE up to MAX_RETRY times instead of IDLE.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   drop_req     level request, only looked at in IDLE
//   t_act/t_lim  measured temperature and limit (unsigned)
//   drop_en      high while in DROP
//   busy         high whenever not IDLE
//   drop_done    one-cycle pulse, first COOL cycle after a full drop
//   drop_abort   one-cycle pulse, first COOL cycle after an abort
//   state_o      current state encoding
module drop_sequencer
   import drop_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int SETTLE_CYC  = 4,
   parameter int TIMEOUT_CYC = 20,
   parameter int DROP_CYC    = 8,
   parameter int COOL_CYC    = 5,
   parameter int MAX_RETRY   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              drop_req,
   input  logic [TEMP_W-1:0] t_act,
   input  logic [TEMP_W-1:0] t_lim,
   output logic              drop_en,
   output logic              busy,
   output logic              drop_done,
   output logic              drop_abort,
   output logic [ST_W-1:0]   state_o
);

   localparam logic [CNT_W-1:0] SETTLE_V  = CNT_W'(SETTLE_CYC);
   localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);
   // Timer is loaded with N-1 so the state lasts exactly N cycles.
   localparam logic [CNT_W-1:0] DROP_LD   = CNT_W'(DROP_CYC - 1);
   localparam logic [CNT_W-1:0] COOL_LD   = CNT_W'(COOL_CYC - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cold_cnt_q, cold_cnt_d;
   logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             done_q, done_d;
   logic             abort_q, abort_d;

   logic             tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_en;
   logic             tmr_zero;
   logic             cold;

`ifdef DROP_AUTO_RETRY_EN
   localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);
   logic [RTY_W-1:0] retry_cnt_q, retry_cnt_d;
   // Remembers whether the current COOL follows an abort (retry-eligible).
   logic             aborted_q, aborted_d;
`endif

   assign cold = is_cold(t_act, t_lim);

   cycle_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .en       (tmr_en),
      .zero     (tmr_zero)
   );

   always_comb begin
      state_d    = state_q;
      cold_cnt_d = cold_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      done_d     = 1'b0;
      abort_d    = 1'b0;
      tmr_load   = 1'b0;
      tmr_val    = '0;
      tmr_en     = 1'b0;
`ifdef DROP_AUTO_RETRY_EN
      retry_cnt_d = retry_cnt_q;
      aborted_d   = aborted_q;
`endif
      case (state_q)
         ST_IDLE: begin
            cold_cnt_d = '0;
            tmo_cnt_d  = '0;
`ifdef DROP_AUTO_RETRY_EN
            retry_cnt_d = '0;
            aborted_d   = 1'b0;
`endif
            if (drop_req) state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            tmo_cnt_d  = tmo_cnt_q + 1'b1;
            cold_cnt_d = cold ? (cold_cnt_q + 1'b1) : '0;
            // Settling completing wins over a coincident timeout.
            if (cold_cnt_d == SETTLE_V) begin
               state_d  = ST_DROP;
               tmr_load = 1'b1;
               tmr_val  = DROP_LD;
            end else if (tmo_cnt_d == TIMEOUT_V) begin
               state_d  = ST_COOL;
               abort_d  = 1'b1;
               tmr_load = 1'b1;
               tmr_val  = COOL_LD;
`ifdef DROP_AUTO_RETRY_EN
               aborted_d = 1'b1;
`endif
            end
         end
         ST_DROP: begin
            // A hot sample aborts even on the final drop cycle.
            if (!cold) begin
               state_d  = ST_COOL;
               abort_d  = 1'b1;
               tmr_load = 1'b1;
               tmr_val  = COOL_LD;
`ifdef DROP_AUTO_RETRY_EN
               aborted_d = 1'b1;
`endif
            end else if (tmr_zero) begin
               state_d  = ST_COOL;
               done_d   = 1'b1;
               tmr_load = 1'b1;
               tmr_val  = COOL_LD;
`ifdef DROP_AUTO_RETRY_EN
               aborted_d   = 1'b0;
               retry_cnt_d = '0;
`endif
            end else begin
               tmr_en = 1'b1;
            end
         end
         ST_COOL: begin
            if (tmr_zero) begin
`ifdef DROP_AUTO_RETRY_EN
               if (aborted_q && (retry_cnt_q < RTY_MAX)) begin
                  state_d     = ST_SETTLE;
                  retry_cnt_d = retry_cnt_q + 1'b1;
                  aborted_d   = 1'b0;
                  cold_cnt_d  = '0;
                  tmo_cnt_d   = '0;
               end else begin
                  state_d = ST_IDLE;
               end
`else
               state_d = ST_IDLE;
`endif
            end else begin
               tmr_en = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cold_cnt_q <= '0;
         tmo_cnt_q  <= '0;
         done_q     <= 1'b0;
         abort_q    <= 1'b0;
`ifdef DROP_AUTO_RETRY_EN
         retry_cnt_q <= '0;
         aborted_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cold_cnt_q <= cold_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
         done_q     <= done_d;
         abort_q    <= abort_d;
`ifdef DROP_AUTO_RETRY_EN
         retry_cnt_q <= retry_cnt_d;
         aborted_q   <= aborted_d;
`endif
      end
   end

   assign drop_en    = (state_q == ST_DROP);
   assign busy       = (state_q != ST_IDLE);
   assign drop_done  = done_q;
   assign drop_abort = abort_q;
   assign state_o    = state_q;

endmodule
